// File: rtl/frame_pkg.sv
// Shared definitions for the frame ingress path: FSM states, default geometry and byte/word scaling.
// FRAME_LOADER_BYTE_SWAP_EN selects the host byte lane order applied on the way into the frame FIFO.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int FIFO_WORDS_DEF  = 32768;
    localparam int BLOCK_WORDS_DEF = 256;

    // FIFO occupancy arrives in bytes; words are 16 bits wide.
    localparam int WORD_SHIFT = 1;

    function automatic logic [15:0] lane_order(input logic [15:0] d);
`ifdef FRAME_LOADER_BYTE_SWAP_EN
        return {d[7:0], d[15:8]};
`else
        return d;
`endif
    endfunction

endpackage

// File: rtl/frame_loader_credit.sv
// Purpose: decides whether the frame FIFO can take one more whole host block (plus margin).
// Latency: space_ok is combinational from fifo_byte_count; inflight tracks the last 2 write strobes.
// Backpressure: none of its own; the loader only grants pipe_ready while space_ok is high.
module frame_loader_credit
    import frame_pkg::*;
#(
    parameter int FIFO_WORDS   = FIFO_WORDS_DEF,
    parameter int BLOCK_WORDS  = BLOCK_WORDS_DEF,
    parameter int MARGIN_WORDS = 2
) (
    input  logic        ti_clk,
    input  logic        rst,
    input  logic [31:0] i_fifo_byte_count,
    input  logic        i_wr_en,
    output logic        o_space_ok
);

    localparam logic signed [33:0] DEPTH = 34'(FIFO_WORDS);
    localparam logic signed [33:0] NEED  = 34'(BLOCK_WORDS + MARGIN_WORDS);

    logic               r_wr_d1;
    logic [1:0]         w_inflight;
    logic [31:0]        w_used;
    logic signed [33:0] w_free;

    always_ff @(posedge ti_clk) begin
        if (rst) begin
            r_wr_d1 <= 1'b0;
        end else begin
            r_wr_d1 <= i_wr_en;
        end
    end

    // Words written recently may not be reflected in the sequencer's byte count yet.
    assign w_inflight = {1'b0, i_wr_en} + {1'b0, r_wr_d1};
    assign w_used     = i_fifo_byte_count >> WORD_SHIFT;
    assign w_free     = DEPTH - $signed({2'b00, w_used}) - $signed({32'd0, w_inflight});
    assign o_space_ok = (w_free >= NEED);

endmodule

// File: rtl/frame_loader.sv
// Purpose: host pipe -> frame FIFO ingress with frame geometry counting (FRAME_LOADER_BYTE_SWAP_EN swaps lanes).
// Latency: pipe_write/pipe_data in cycle N appear as fifo_wr_en/fifo_din in cycle N+1.
// Backpressure: pipe_ready granted per whole block when FIFO space allows; writes while not ready are dropped.
module frame_loader
    import frame_pkg::*;
#(
    parameter int FIFO_WORDS   = FIFO_WORDS_DEF,
    parameter int BLOCK_WORDS  = BLOCK_WORDS_DEF,
    parameter int MARGIN_WORDS = 2
) (
    input  logic        ti_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] reg_length,
    input  logic [31:0] reg_delay,
    input  logic        pipe_write,
    input  logic [15:0] pipe_data,
    output logic        pipe_ready,
    input  logic [31:0] fifo_byte_count,
    output logic [15:0] fifo_din,
    output logic        fifo_wr_en,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        cfg_err,
    output logic [31:0] words_written,
    output logic [15:0] cols_written
);

    localparam logic [1:0]  S_IDLE   = ST_IDLE;
    localparam logic [1:0]  S_ARM    = ST_ARM;
    localparam logic [1:0]  S_ACCEPT = ST_ACCEPT;
    localparam logic [1:0]  S_DONE   = ST_DONE;
    localparam logic [15:0] BLK_LAST = 16'(BLOCK_WORDS - 1);

    logic [1:0]  r_state;
    logic [30:0] r_wpc;
    logic [15:0] r_cols;
    logic [30:0] r_word_in_col;
    logic [15:0] r_blk_cnt;
    logic [31:0] r_words;
    logic [15:0] r_cols_done;
    logic        r_pipe_ready;
    logic        r_wr_en;
    logic [15:0] r_din;
    logic        r_busy;
    logic        r_done;
    logic        r_ovf;
    logic        r_cfg_err;

    logic        w_space_ok;
    logic        w_accept;
    logic        w_drop;
    logic        w_col_end;
    logic        w_frame_end;
    logic        w_blk_end;
    logic [30:0] w_start_wpc;
    logic [15:0] w_start_cols;
    logic        w_geom_ok;
    logic        w_unused;

    frame_loader_credit #(
        .FIFO_WORDS   (FIFO_WORDS),
        .BLOCK_WORDS  (BLOCK_WORDS),
        .MARGIN_WORDS (MARGIN_WORDS)
    ) u_credit (
        .ti_clk            (ti_clk),
        .rst               (rst),
        .i_fifo_byte_count (fifo_byte_count),
        .i_wr_en           (r_wr_en),
        .o_space_ok        (w_space_ok)
    );

    assign w_start_wpc  = reg_length[31:1];
    assign w_start_cols = reg_delay[15:0];
    assign w_geom_ok    = (|w_start_wpc) && (|w_start_cols);
    assign w_unused     = ^{reg_length[0], reg_delay[31:16]};

    // pipe_ready is only ever high in ACCEPT, so an accepted word implies ACCEPT.
    assign w_accept    = pipe_write && r_pipe_ready;
    assign w_drop      = pipe_write && !r_pipe_ready;
    assign w_col_end   = (r_word_in_col == r_wpc - 31'd1);
    assign w_frame_end = w_col_end && (r_cols_done == r_cols - 16'd1);
    assign w_blk_end   = (r_blk_cnt == BLK_LAST);

    always_ff @(posedge ti_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wpc         <= '0;
            r_cols        <= '0;
            r_word_in_col <= '0;
            r_blk_cnt     <= '0;
            r_words       <= '0;
            r_cols_done   <= '0;
            r_pipe_ready  <= 1'b0;
            r_wr_en       <= 1'b0;
            r_din         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_ovf         <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_din <= lane_order(pipe_data);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wpc  <= w_start_wpc;
                        r_cols <= w_start_cols;
                        if (!w_geom_ok) begin
                            r_cfg_err <= 1'b1;
                            r_done    <= 1'b1;
                        end else begin
                            r_cfg_err     <= 1'b0;
                            r_ovf         <= 1'b0;
                            r_words       <= '0;
                            r_cols_done   <= '0;
                            r_word_in_col <= '0;
                            r_busy        <= 1'b1;
                            r_state       <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (w_space_ok) begin
                        r_pipe_ready <= 1'b1;
                        r_blk_cnt    <= '0;
                        r_state      <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (w_accept) begin
                        r_words   <= r_words + 32'd1;
                        r_blk_cnt <= r_blk_cnt + 16'd1;
                        if (w_col_end) begin
                            r_word_in_col <= '0;
                            r_cols_done   <= r_cols_done + 16'd1;
                        end else begin
                            r_word_in_col <= r_word_in_col + 31'd1;
                        end
                        // Frame end wins over a coincident block end.
                        if (w_frame_end) begin
                            r_pipe_ready <= 1'b0;
                            r_state      <= S_DONE;
                        end else if (w_blk_end) begin
                            r_pipe_ready <= 1'b0;
                            r_state      <= S_ARM;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign pipe_ready    = r_pipe_ready;
    assign fifo_wr_en    = r_wr_en;
    assign fifo_din      = r_din;
    assign busy          = r_busy;
    assign frame_done    = r_done;
    assign overflow      = r_ovf;
    assign cfg_err       = r_cfg_err;
    assign words_written = r_words;
    assign cols_written  = r_cols_done;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: directed scenarios plus randomized host traffic against a reference model.
// Build with FRAME_LOADER_BYTE_SWAP_EN defined to exercise the swapped lane order.
module tb_frame_loader;

    localparam int FIFO_W  = 32768;
    localparam int BLOCK_W = 256;
    localparam int MARGIN  = 2;

    logic        ti_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] reg_length = '0;
    logic [31:0] reg_delay = '0;
    logic        pipe_write = 1'b0;
    logic [15:0] pipe_data = '0;
    logic [31:0] fbc = '0;
    logic        pipe_ready;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        cfg_err;
    logic [31:0] words_written;
    logic [15:0] cols_written;

    int n_checks = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    frame_loader #(
        .FIFO_WORDS   (FIFO_W),
        .BLOCK_WORDS  (BLOCK_W),
        .MARGIN_WORDS (MARGIN)
    ) dut (
        .ti_clk          (ti_clk),
        .rst             (rst),
        .start           (start),
        .reg_length      (reg_length),
        .reg_delay       (reg_delay),
        .pipe_write      (pipe_write),
        .pipe_data       (pipe_data),
        .pipe_ready      (pipe_ready),
        .fifo_byte_count (fbc),
        .fifo_din        (fifo_din),
        .fifo_wr_en      (fifo_wr_en),
        .busy            (busy),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .cfg_err         (cfg_err),
        .words_written   (words_written),
        .cols_written    (cols_written)
    );

    always #5 ti_clk = ~ti_clk;

    function automatic logic [15:0] swap_exp(input logic [15:0] d);
`ifdef FRAME_LOADER_BYTE_SWAP_EN
        return {d[7:0], d[15:8]};
`else
        return d;
`endif
    endfunction

    // Reference model: expected output values for the current cycle.
    bit       m_ready, m_wr, m_busy, m_done, m_ovf, m_cfg, m_fin, m_prev_wr;
    logic [15:0] m_din;
    longint   m_words, m_cols_out, m_wpc, m_ncols, m_blkbase;

    task automatic model_step();
        bit     acc, drop;
        longint infl, freew, wpc, ncols;
        if (rst) begin
            m_ready = 0; m_wr = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_cfg = 0;
            m_fin = 0; m_prev_wr = 0; m_din = '0; m_words = 0; m_cols_out = 0;
            return;
        end
        acc  = pipe_write && m_ready;
        drop = pipe_write && !m_ready;
        infl = longint'(m_wr) + longint'(m_prev_wr);
        m_prev_wr = m_wr;
        m_wr = acc;
        if (acc) m_din = swap_exp(pipe_data);
        m_done = 0;
        if (acc) begin
            m_words++;
            m_cols_out = m_words / m_wpc;
            if (m_words == m_wpc * m_ncols) begin
                m_ready = 0;
                m_fin = 1;
            end else if (m_words - m_blkbase == BLOCK_W) begin
                m_ready = 0;
            end
        end else if (m_busy && !m_ready && !m_fin) begin
            freew = longint'(FIFO_W) - longint'(fbc / 2) - infl;
            if (freew >= BLOCK_W + MARGIN) begin
                m_ready = 1;
                m_blkbase = m_words;
            end
        end else if (m_fin) begin
            m_fin = 0;
            m_done = 1;
            m_busy = 0;
        end else if (!m_busy && start) begin
            wpc   = longint'(reg_length / 2);
            ncols = longint'(reg_delay % 65536);
            if (wpc == 0 || ncols == 0) begin
                m_cfg = 1;
                m_done = 1;
            end else begin
                m_wpc = wpc; m_ncols = ncols;
                m_cfg = 0; m_ovf = 0;
                m_words = 0; m_cols_out = 0;
                m_busy = 1;
            end
        end
        if (drop) m_ovf = 1;
    endtask

    always @(posedge ti_clk) model_step();

    always @(negedge ti_clk) begin
        logic [53:0] act, exp_v;
        if (cmp_en) begin
            act   = {pipe_ready, fifo_wr_en, busy, frame_done, overflow, cfg_err, words_written, cols_written};
            exp_v = {m_ready, m_wr, m_busy, m_done, m_ovf, m_cfg, 32'(m_words), 16'(m_cols_out)};
            n_checks++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL model_outputs t=%0t got %h expected %h", $time, act, exp_v);
            end
            if (m_wr) begin
                n_checks++;
                if (fifo_din !== m_din) begin
                    n_err++;
                    $display("FAIL model_din t=%0t got %h expected %h", $time, fifo_din, m_din);
                end
            end
        end
    end

    task automatic tick();
        @(negedge ti_clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic do_start(input logic [31:0] len, input logic [31:0] dly);
        reg_length = len;
        reg_delay = dly;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int lim);
        for (int i = 0; i < lim && !pipe_ready; i++) tick();
        chk(name, 64'(pipe_ready), 64'd1);
    endtask

    task automatic wait_idle(input string name, input int lim);
        for (int i = 0; i < lim && busy; i++) tick();
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic host_write(input logic [15:0] d);
        pipe_write = 1'b1;
        pipe_data = d;
        tick();
        pipe_write = 1'b0;
    endtask

    int unsigned fbc_opts[6] = '{0, 64000, 65018, 65020, 65022, 65024};

    initial begin
        logic [15:0] d;
        int unsigned r, wpc, ncols;
        repeat (3) tick();
        cmp_en = 1'b1;
        chk("reset_outputs", {pipe_ready, fifo_wr_en, busy, frame_done, overflow, cfg_err, words_written, cols_written, fifo_din}, 64'd0);
        rst = 1'b0;

        // Basic frame: 4 words/column, 2 columns.
        fbc = 0;
        do_start(32'd8, 32'd2);
        chk("basic_busy", 64'(busy), 64'd1);
        wait_ready("basic_ready", 4);
        for (int i = 1; i <= 8; i++) begin
            d = {8'(i), 8'(i)};
            host_write(d);
            chk("basic_wr_en", 64'(fifo_wr_en), 64'd1);
            chk("basic_din", 64'(fifo_din), 64'(swap_exp(d)));
        end
        chk("basic_ready_drop", 64'(pipe_ready), 64'd0);
        chk("basic_no_early_done", 64'(frame_done), 64'd0);
        tick();
        chk("basic_done", {frame_done, busy, words_written, cols_written}, {15'd0, 1'b1, 1'b0, 32'd8, 16'd2});

        // Flow control: exactly 256 words free is not enough.
        fbc = 65024;
        do_start(32'd8, 32'd1);
        repeat (5) tick();
        chk("flow_held", 64'(pipe_ready), 64'd0);
        fbc = 64000;
        wait_ready("flow_release", 2);
        for (int i = 0; i < 4; i++) host_write(16'(i));
        tick();
        wait_idle("flow_idle", 4);

        // Block boundary: 512 words in one column.
        fbc = 0;
        do_start(32'd1024, 32'd1);
        wait_ready("blk_ready0", 4);
        for (int i = 0; i < 256; i++) host_write(16'(i));
        chk("blk_drop256", 64'(pipe_ready), 64'd0);
        wait_ready("blk_ready1", 5);
        for (int i = 256; i < 512; i++) host_write(16'(i));
        chk("blk_drop512", {pipe_ready, cols_written}, {47'd0, 1'b0, 16'd1});
        tick();
        chk("blk_done", 64'(frame_done), 64'd1);

        // Drop and flag.
        host_write(16'hdead);
        chk("drop_no_write", {fifo_wr_en, overflow}, 64'b01);
        repeat (3) tick();
        chk("drop_sticky", 64'(overflow), 64'd1);
        do_start(32'd2, 32'd1);
        chk("drop_cleared", 64'(overflow), 64'd0);
        wait_ready("drop_ready", 4);
        host_write(16'h0042);
        tick();
        wait_idle("drop_idle", 4);

        // Illegal geometry.
        do_start(32'd1, 32'd5);
        chk("cfg_len", {cfg_err, frame_done, busy}, 64'b110);
        tick();
        chk("cfg_pulse_end", {cfg_err, frame_done}, 64'b10);
        do_start(32'd4, 32'h0001_0000);
        chk("cfg_cols", {cfg_err, frame_done, busy}, 64'b110);

        // Reset mid-frame.
        do_start(32'd16, 32'd1);
        wait_ready("rst_ready", 4);
        for (int i = 0; i < 3; i++) host_write(16'h0a00 + 16'(i));
        rst = 1'b1;
        pipe_write = 1'b1;
        pipe_data = 16'h0bbb;
        tick();
        pipe_write = 1'b0;
        chk("rst_outputs", {pipe_ready, fifo_wr_en, busy, frame_done, overflow, cfg_err, words_written, cols_written, fifo_din}, 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_quiet", {fifo_wr_en, pipe_ready, busy}, 64'd0);
        do_start(32'd2, 32'd1);
        wait_ready("swap_ready", 4);
        host_write(16'h1234);
`ifdef FRAME_LOADER_BYTE_SWAP_EN
        chk("lane_order", 64'(fifo_din), 64'h3412);
`else
        chk("lane_order", 64'(fifo_din), 64'h1234);
`endif
        tick();

        // Randomized host traffic.
        for (int c = 0; c < 15000; c++) begin
            if (c % 37 == 0) begin
                r = $urandom_range(0, 9);
                fbc = (r < 6) ? fbc_opts[r] : 32'd0;
            end
            start = 1'b0;
            pipe_write = 1'b0;
            rst = 1'b0;
            r = $urandom_range(0, 999);
            if (!m_busy && r < 60) begin
                start = 1'b1;
                r = $urandom_range(0, 9);
                wpc = (r == 0) ? 0 : (r == 1) ? $urandom_range(100, 300) : $urandom_range(1, 20);
                ncols = (r == 2) ? 0 : (r == 1) ? $urandom_range(1, 2) : $urandom_range(1, 6);
                reg_length = 32'(wpc * 2 + $urandom_range(0, 1));
                reg_delay = {16'($urandom), 16'(ncols)};
            end else if (m_busy && r < 5) begin
                start = 1'b1;
                reg_length = 32'd6;
                reg_delay = 32'd3;
            end
            if (m_ready && $urandom_range(0, 3) != 0) begin
                pipe_write = 1'b1;
                pipe_data = 16'($urandom);
            end else if (!m_ready && !start && $urandom_range(0, 99) == 0) begin
                pipe_write = 1'b1;
                pipe_data = 16'($urandom);
            end
            if ($urandom_range(0, 1999) == 0) rst = 1'b1;
            tick();
        end
        start = 1'b0;
        pipe_write = 1'b0;
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
